// File: rtl/centscale_window_pkg.sv
`default_nettype none
// ============================================================================
// Module   : centscale_window_pkg
// Purpose  : Shared definitions for the centre/scale windowing stage:
//            SMC-float word width, stream FSM encoding, ring address width.
// Revision : 1.0 - initial release
// ============================================================================
package centscale_window_pkg;

  // SMC-float sample width; samples pass through bit-exact.
  localparam int SMC_W = 32;

  // Window streaming state machine encoding.
  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } win_state_e;

  // The ring holds two full windows (the active one and a queued one), so
  // its address width is log2(2*WIN). WIN is a power of two, so pointer
  // arithmetic wraps naturally modulo the ring depth.
  function automatic int ring_aw(input int win);
    return $clog2(2 * win);
  endfunction

endpackage
`default_nettype wire

// File: rtl/centscale_ring.sv
`default_nettype none
// ============================================================================
// Module   : centscale_ring
// Purpose  : DEPTH x SMC_W register-file ring. One write port, one registered
//            read port. A read and a write of the same address in the same
//            cycle returns the previously stored word. The read register
//            returns zero on cycles without a read so the streamed output is
//            clean whenever it is not valid.
// Revision : 1.0 - initial release
// ============================================================================
module centscale_ring
  import centscale_window_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [SMC_W-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [SMC_W-1:0] rd_data
);

  logic [SMC_W-1:0] mem [DEPTH];

  // Storage array: plain registers, no reset (contents are don't-care
  // until written).
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port: samples the array before this edge's write lands,
  // so a same-address collision yields the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/centscale_window.sv
`default_nettype none
// ============================================================================
// Module   : centscale_window
// Purpose  : Collects centred/scaled SMC-float samples into a ring and, each
//            time a full window is available, streams that window oldest
//            first with first/last framing. Windows overlap by WIN-HOP
//            samples. One further window may be queued while one streams;
//            a trigger beyond that is dropped and flagged by a sticky
//            overrun bit.
// Revision : 1.0 - initial release
// ============================================================================
module centscale_window
  import centscale_window_pkg::*;
#(
  parameter int WIN = 8,
  parameter int HOP = 4
) (
  input  logic             clk,
  input  logic             GlobalReset,
  input  logic             flush_i,
  input  logic [SMC_W-1:0] x_i,
  input  logic             srdyi_i,
  output logic [SMC_W-1:0] win_o,
  output logic             srdyo_o,
  output logic             first_o,
  output logic             last_o,
  output logic             overrun_o
);

  // Derived ring geometry; not meant to be overridden.
  localparam int            AW     = ring_aw(WIN);
  localparam int            DEPTH  = 2 * WIN;
  localparam logic [AW-1:0] WIN_A  = AW'(WIN);
  localparam logic [AW-1:0] WIN_M1 = AW'(WIN - 1);
  localparam logic [AW-1:0] HOP_M1 = AW'(HOP - 1);

  // Ingress state
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] wr_ptr_inc;
  logic [AW-1:0] fill;
  logic [AW-1:0] fill_nx;
  logic [AW-1:0] hop_cnt;
  logic [AW-1:0] hop_nx;
  logic          accept;
  logic          trigger;
  logic [AW-1:0] trig_base;

  // Stream state
  win_state_e    state;
  logic [AW-1:0] base;
  logic [AW-1:0] pend_base;
  logic          pending;
  logic [AW-1:0] rd_cnt;
  logic [AW-1:0] rd_addr;
  logic          rd_en;
  logic          last_rd;

  // A flush discards any sample offered in the same cycle.
  assign accept     = srdyi_i & ~flush_i;
  assign wr_ptr_inc = wr_ptr + 1'b1;

  // Oldest sample of the window that ends with the word being written now.
  assign trig_base  = wr_ptr_inc - WIN_A;

  assign rd_addr    = base + rd_cnt;
  assign last_rd    = (rd_cnt == WIN_M1);
  assign rd_en      = (state == ST_STREAM) && !flush_i;

  // Window trigger: first after WIN samples, then after every HOP samples.
  always_comb begin
    fill_nx = fill;
    hop_nx  = hop_cnt;
    trigger = 1'b0;
    if (accept) begin
      if (fill != WIN_A) begin
        fill_nx = fill + 1'b1;
        trigger = (fill_nx == WIN_A);
      end else if (hop_cnt == HOP_M1) begin
        hop_nx  = '0;
        trigger = 1'b1;
      end else begin
        hop_nx  = hop_cnt + 1'b1;
      end
    end
  end

  // Ingress bookkeeping: write pointer, fill level and hop counter.
  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      wr_ptr  <= '0;
      fill    <= '0;
      hop_cnt <= '0;
    end else if (flush_i) begin
      wr_ptr  <= '0;
      fill    <= '0;
      hop_cnt <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr_inc;
      end
      fill    <= fill_nx;
      hop_cnt <= hop_nx;
    end
  end

  // Stream FSM with one-deep window queue and registered framing outputs.
  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      state     <= ST_IDLE;
      base      <= '0;
      pend_base <= '0;
      pending   <= 1'b0;
      rd_cnt    <= '0;
      srdyo_o   <= 1'b0;
      first_o   <= 1'b0;
      last_o    <= 1'b0;
      overrun_o <= 1'b0;
    end else if (flush_i) begin
      state     <= ST_IDLE;
      base      <= '0;
      pend_base <= '0;
      pending   <= 1'b0;
      rd_cnt    <= '0;
      srdyo_o   <= 1'b0;
      first_o   <= 1'b0;
      last_o    <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      srdyo_o <= 1'b0;
      first_o <= 1'b0;
      last_o  <= 1'b0;
      if (state == ST_IDLE) begin
        if (trigger) begin
          base   <= trig_base;
          rd_cnt <= '0;
          state  <= ST_STREAM;
        end
      end else begin
        // The ring read for rd_cnt is issued on this edge; its framing
        // is registered alongside so all outputs line up.
        srdyo_o <= 1'b1;
        first_o <= (rd_cnt == '0);
        last_o  <= last_rd;
        if (last_rd) begin
          rd_cnt <= '0;
          // The queue slot frees on this edge, so a coincident trigger
          // is queued rather than dropped.
          if (pending) begin
            base <= pend_base;
            if (trigger) begin
              pend_base <= trig_base;
            end else begin
              pending <= 1'b0;
            end
          end else if (trigger) begin
            base <= trig_base;
          end else begin
            state <= ST_IDLE;
          end
        end else begin
          rd_cnt <= rd_cnt + 1'b1;
          if (trigger) begin
            if (!pending) begin
              pend_base <= trig_base;
              pending   <= 1'b1;
            end else begin
              overrun_o <= 1'b1;
            end
          end
        end
      end
    end
  end

  // Two-window ring: the active and the queued window are both retained
  // until read, since a window is never more than 2*WIN samples old when
  // its last word is fetched.
  centscale_ring #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ring (
    .clk     (clk),
    .rst_n   (GlobalReset),
    .wr_en   (accept),
    .wr_addr (wr_ptr),
    .wr_data (x_i),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (win_o)
  );

endmodule
`default_nettype wire
